// File: rtl/br_resolve.sv
// Branch resolution / misprediction recovery for EX. Carries IF prediction tags to EX,
// redirects on mismatch, and holds a pending redirect across pc_stall. Optional counters: BR_PERF_CNT_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module br_resolve #(
  parameter int PC_WIDTH = `PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic                pc_stall,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                predt_br_taken,
  input  logic [PC_WIDTH-1:0] predt_pc,
  input  logic                trap_happened,
  input  logic                mret_en,
  input  logic                ex_is_branch,
  input  logic                ex_is_jump,
  input  logic                ex_br_cond,
  input  logic [PC_WIDTH-1:0] ex_target,
  output logic                br_taken,
  output logic [PC_WIDTH-1:0] br_addr,
  output logic                flush,
  output logic [31:0]         br_total_cnt,
  output logic [31:0]         br_miss_cnt
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic                  id_valid_q, id_pt_q, ex_valid_q, ex_pt_q;
  logic [PC_WIDTH-1:0]   id_pc_q, id_ppc_q, ex_pc_q, ex_ppc_q;

  logic                  kill, act_taken, miss;
  logic [PC_WIDTH-1:0]   seq_pc, act_next, pred_next;

  assign kill      = trap_happened | mret_en;
  assign seq_pc    = ex_pc_q + PC_WIDTH'(4);
  assign act_taken = ex_is_jump | (ex_is_branch & ex_br_cond);
  assign act_next  = act_taken ? ex_target : seq_pc;
  assign pred_next = ex_pt_q ? ex_ppc_q : seq_pc;
  assign miss      = ex_valid_q & (pred_next != act_next);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // next state
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    if (cpu_en) begin
      if (kill) begin
        state_d     = IDLE;
        pend_addr_d = '0;
      end else begin
        case (state_q)
          IDLE: if (br_taken && pc_stall) begin
            state_d     = PEND;
            pend_addr_d = act_next;
          end
          PEND: if (!pc_stall) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // outputs; a pending redirect ignores any new miss
  always_comb begin
    br_taken = 1'b0;
    br_addr  = '0;
    case (state_q)
      IDLE: begin
        br_taken = miss & cpu_en & ~kill;
        br_addr  = br_taken ? act_next : '0;
      end
      PEND: begin
        br_taken = ~kill;
        br_addr  = br_taken ? pend_addr_q : '0;
      end
      default: ;
    endcase
  end

  assign flush = br_taken;

  // tag pipeline; ID is held under stall so id_valid survives until the redirect is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_pt_q    <= 1'b0;
      id_ppc_q   <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_pt_q    <= 1'b0;
      ex_ppc_q   <= '0;
    end else if (cpu_en) begin
      if (kill) begin
        id_valid_q <= 1'b0;
        ex_valid_q <= 1'b0;
      end else if (pc_stall) begin
        ex_valid_q <= 1'b0;
      end else if (flush) begin
        id_valid_q <= 1'b0;
        ex_valid_q <= 1'b0;
      end else begin
        id_valid_q <= 1'b1;
        id_pc_q    <= pc;
        id_pt_q    <= predt_br_taken;
        id_ppc_q   <= predt_pc;
        ex_valid_q <= id_valid_q;
        ex_pc_q    <= id_pc_q;
        ex_pt_q    <= id_pt_q;
        ex_ppc_q   <= id_ppc_q;
      end
    end
  end

`ifdef BR_PERF_CNT_EN
  logic [31:0] total_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q    <= '0;
      miss_cnt_q <= '0;
    end else if (cpu_en && !kill) begin
      if (ex_valid_q && (ex_is_branch || ex_is_jump)) total_q <= total_q + 32'd1;
      if (state_q == IDLE && br_taken) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign br_total_cnt = total_q;
  assign br_miss_cnt  = miss_cnt_q;
`else
  assign br_total_cnt = 32'd0;
  assign br_miss_cnt  = 32'd0;
`endif

endmodule
